// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the {pc, inst} record passed from fetch to decode.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} records with a zero-latency head.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);
    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;
    logic          full;

    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps up to FIFO_DEPTH reads in flight and
// hands {pc, inst} to decode; a redirect flushes and restarts at a new PC.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              FIFO_DEPTH   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_inst_valid,
    output logic [ILEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [XLEN-1:0] RESET_PC = RESET_VECTOR & ~XLEN'(3);

    logic [XLEN-1:0] pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   discard_reg;
    logic [XLEN-1:0] pcq_reg [FIFO_DEPTH];
    logic [PW-1:0]   pcq_rd_reg;
    logic [PW-1:0]   pcq_wr_reg;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wr_data;
    logic [OW-1:0]   occupancy;
    logic [XLEN-1:0] redirect_pc;
    logic            transfer;
    logic            drop_resp;
    logic            fifo_push;
    logic            fifo_pop;

    // Every in-flight request holds a buffer slot, so a response always fits.
    assign occupancy   = OW'(outstanding_reg) + OW'(fifo_count);
    assign o_imem_req  = !i_rst && !i_redirect && (occupancy < OW'(FIFO_DEPTH));
    assign o_imem_addr = pc_reg;
    assign transfer    = o_imem_req && i_imem_ack;
    assign redirect_pc = i_redirect_pc & ~XLEN'(3);

    assign drop_resp    = (discard_reg != '0);
    assign fifo_push    = i_imem_rvalid && !drop_resp && !i_redirect;
    assign fifo_pop     = o_inst_valid && i_inst_ready && !i_redirect;
    assign fifo_wr_data = '{pc: pcq_reg[pcq_rd_reg], inst: i_imem_rdata};

    assign o_inst_valid = !i_rst && (fifo_count != '0);
    assign o_inst       = o_inst_valid ? fifo_head.inst : NOP_INST;
    assign o_inst_pc    = o_inst_valid ? fifo_head.pc : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .srst    (i_rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (i_redirect),
        .wr_data (fifo_wr_data),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            pcq_rd_reg      <= '0;
            pcq_wr_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(transfer) - CW'(i_imem_rvalid);
            if (transfer) begin
                pcq_wr_reg <= (pcq_wr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : pcq_wr_reg + 1'b1;
            end
            if (i_imem_rvalid) begin
                pcq_rd_reg <= (pcq_rd_reg == PW'(FIFO_DEPTH - 1)) ? '0 : pcq_rd_reg + 1'b1;
            end
            if (i_redirect) begin
                pc_reg      <= redirect_pc;
                // Everything still in flight after this cycle is stale, including
                // requests already marked for discard by an earlier redirect.
                discard_reg <= outstanding_reg - CW'(i_imem_rvalid);
            end else begin
                if (transfer) begin
                    pc_reg <= pc_reg + XLEN'(4);
                end
                if (i_imem_rvalid && drop_resp) begin
                    discard_reg <= discard_reg - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (transfer) begin
            pcq_reg[pcq_wr_reg] <= pc_reg;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model feeds the DUT and a
// scoreboard checks every decode handshake against the expected fetch stream.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    int hs_cnt = 0;
    logic        ack_en = 1'b1;
    logic [31:0] last_hs_pc = 32'h0;
    logic [31:0] mem_q [$];
    int          mem_due [$];
    logic [31:0] xa_q [$];
    logic [31:0] sb_pc_q [$];
    logic [31:0] sb_inst_q [$];
    logic [31:0] hs_inst_log [$];

    fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0003;
            32'h0000_0004: return 32'h00A0_0093;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected in-order stream from a fetch start point.
    task automatic new_stream(input logic [31:0] start);
        logic [31:0] a;
        sb_pc_q.delete();
        sb_inst_q.delete();
        a = start & 32'hFFFF_FFFC;
        for (int k = 0; k < 64; k++) begin
            sb_pc_q.push_back(a);
            sb_inst_q.push_back(mem_word(a));
            a = a + 32'd4;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int t = 0;
        while (xa_q.size() < n && t < budget) begin
            step();
            t++;
        end
        if (xa_q.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL xfer_timeout: got %0d transfers expected %0d", xa_q.size(), n);
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int t = 0;
        while (hs_cnt < target && t < budget) begin
            step();
            t++;
        end
        if (hs_cnt < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_cnt, target);
        end
    endtask

    // Memory model: drives the response at negedge, samples the bus just before posedge.
    always @(negedge clk) begin
        if (mem_q.size() > 0 && mem_due[0] <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(mem_q[0]);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 32'h0;
        end
        i_imem_ack = ack_en;
        #4;
        if (i_imem_rvalid && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            void'(mem_due.pop_front());
        end
        if (i_rst) begin
            mem_q.delete();
            mem_due.delete();
        end
        if (o_imem_req && i_imem_ack) begin
            mem_q.push_back(o_imem_addr);
            mem_due.push_back(cyc + lat);
            xa_q.push_back(o_imem_addr);
        end
    end

    // Monitor: pops the scoreboard on every honoured decode handshake.
    always @(negedge clk) begin
        #4;
        if (!i_rst && !i_redirect && o_inst_valid && i_inst_ready) begin
            hs_cnt++;
            last_hs_pc = o_inst_pc;
            hs_inst_log.push_back(o_inst);
            $display("decode pc=%h inst=%h", o_inst_pc, o_inst);
            if (sb_pc_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL hs_unexpected: got pc %h expected no output", o_inst_pc);
            end else begin
                chk("hs_pc", o_inst_pc, sb_pc_q.pop_front());
                chk("hs_inst", o_inst, sb_inst_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset values
        repeat (3) step();
        settle();
        chk("rst_req", 32'(o_imem_req), 32'h0);
        chk("rst_valid", 32'(o_inst_valid), 32'h0);
        chk("rst_inst", o_inst, 32'h0000_0013);
        chk("rst_pc", o_inst_pc, 32'h0);

        // Test 1: release, straight-line fetch
        step();
        i_rst = 1'b0;
        new_stream(32'h0);
        xa_q.delete();
        hs_inst_log.delete();
        settle();
        chk("t1_req", 32'(o_imem_req), 32'h1);
        chk("t1_addr0", o_imem_addr, 32'h0);
        chk("t1_idle_inst", o_inst, 32'h0000_0013);
        wait_xfers(2, 20);
        chk("t1_xa0", xa_q[0], 32'h0);
        chk("t1_xa1", xa_q[1], 32'h4);
        wait_hs(2, 20);
        chk("t1_inst0", hs_inst_log[0], 32'h0000_0003);
        chk("t1_inst1", hs_inst_log[1], 32'h00A0_0093);

        // Test 2: decode stalls for 10 cycles after a restart at 0x100
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        i_inst_ready  = 1'b0;
        new_stream(32'h100);
        xa_q.delete();
        step();
        i_redirect = 1'b0;
        repeat (10) step();
        settle();
        chk("t2_nxfer", 32'(xa_q.size()), 32'd2);
        chk("t2_xa0", xa_q[0], 32'h100);
        chk("t2_xa1", xa_q[1], 32'h104);
        chk("t2_req", 32'(o_imem_req), 32'h0);
        chk("t2_valid", 32'(o_inst_valid), 32'h1);
        chk("t2_head_pc", o_inst_pc, 32'h100);
        step();
        i_inst_ready = 1'b1;
        base = hs_cnt;
        wait_hs(base + 4, 30);

        // Test 3: redirect to an unaligned target with two requests outstanding
        lat = 4;
        begin
            int t = 0;
            while (mem_q.size() != 2 && t < 20) begin
                step();
                t++;
            end
        end
        chk("t3_outstanding", 32'(mem_q.size()), 32'd2);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_1002;
        new_stream(32'h1000);
        xa_q.delete();
        base = hs_cnt;
        step();
        i_redirect = 1'b0;
        wait_xfers(1, 30);
        chk("t3_xa0", xa_q[0], 32'h1000);
        wait_hs(base + 1, 40);
        chk("t3_first_pc", last_hs_pc, 32'h1000);

        // Test 4: redirect with rvalid in the same cycle, then a second redirect
        lat = 2;
        begin
            int t = 0;
            while (!i_imem_rvalid && t < 20) begin
                step();
                t++;
            end
        end
        chk("t4_rvalid", 32'(i_imem_rvalid), 32'h1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_2000;
        new_stream(32'h2000);
        step();
        i_redirect_pc = 32'h0000_3000;
        new_stream(32'h3000);
        base = hs_cnt;
        step();
        i_redirect = 1'b0;
        wait_hs(base + 4, 40);
        chk("t4_last_pc", last_hs_pc, 32'h300C);

        // Test 5: fetch across the top of the address space
        lat = 1;
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        new_stream(32'hFFFF_FFF8);
        xa_q.delete();
        base = hs_cnt;
        step();
        i_redirect = 1'b0;
        wait_xfers(3, 30);
        chk("t5_xa0", xa_q[0], 32'hFFFF_FFF8);
        chk("t5_xa1", xa_q[1], 32'hFFFF_FFFC);
        chk("t5_xa2", xa_q[2], 32'h0000_0000);
        wait_hs(base + 3, 30);
        chk("t5_wrap_pc", last_hs_pc, 32'h0);

        // Test 6: reset with the output buffer full
        step();
        i_inst_ready = 1'b0;
        repeat (8) step();
        settle();
        chk("t6_full_valid", 32'(o_inst_valid), 32'h1);
        chk("t6_full_req", 32'(o_imem_req), 32'h0);
        step();
        i_rst = 1'b1;
        step();
        settle();
        chk("t6_rst_valid", 32'(o_inst_valid), 32'h0);
        chk("t6_rst_req", 32'(o_imem_req), 32'h0);
        chk("t6_rst_inst", o_inst, 32'h0000_0013);
        step();
        i_rst        = 1'b0;
        i_inst_ready = 1'b1;
        new_stream(32'h0);
        xa_q.delete();
        base = hs_cnt;
        settle();
        chk("t6_req", 32'(o_imem_req), 32'h1);
        chk("t6_addr", o_imem_addr, 32'h0);
        wait_hs(base + 3, 30);
        chk("t6_last_pc", last_hs_pc, 32'h8);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
